// File: rtl/frame_writer.sv
// Frame loader: packs pairs of stream bytes into RGB444 pixels and writes them
// row-major into a frame RAM, with start/abort control and a done pulse.
module frame_writer #(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        W,
   input  logic [7:0]        H,
   input  logic              start,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [11:0]       ram_wdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {S_IDLE, S_HI, S_LO, S_WR, S_FIN} state_t;

   state_t            state_q, state_d;
   logic [15:0]       total_q, total_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [11:0]       ram_wdata_q, ram_wdata_d;
   logic              byte_ready_q, byte_ready_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept;
   logic [15:0]       prod;

   assign prod   = {8'h00, W} * {8'h00, H};
   assign accept = byte_valid & byte_ready_q & ~abort;

   always_comb begin
      state_d     = state_q;
      total_d     = total_q;
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            total_d = prod;
            cnt_d   = '0;
            state_d = (prod == 16'd0) ? S_FIN : S_HI;
         end
         S_HI: if (accept) begin
            hi_d    = byte_data;
            state_d = S_LO;
         end
         // Address/data are loaded as the WR cycle begins so they stay put between writes.
         S_LO: if (accept) begin
            ram_addr_d  = ADDR_W'(cnt_q);
            ram_wdata_d = {hi_q, byte_data[7:4]};
            state_d     = S_WR;
         end
         S_WR: begin
            if (cnt_q == total_q - 16'd1) begin
               state_d = S_FIN;
            end else begin
               cnt_d   = cnt_q + 16'd1;
               state_d = S_HI;
            end
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         hi_d    = '0;
      end
      byte_ready_d = (state_d == S_HI) || (state_d == S_LO);
      busy_d       = byte_ready_d || (state_d == S_WR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         total_q      <= '0;
         cnt_q        <= '0;
         hi_q         <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         byte_ready_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         total_q      <= total_d;
         cnt_q        <= cnt_d;
         hi_q         <= hi_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         byte_ready_q <= byte_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // Abort must be able to kill the write in the same cycle, hence the gate.
   assign ram_we     = (state_q == S_WR) & ~abort;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign byte_ready = byte_ready_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer: table of frame shapes with random bytes checked
// against a pixel-list model, plus hand sequences for abort/restart/reset.
module tb_frame_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  W = '0, H = '0;
   logic        start = 1'b0, abort = 1'b0, byte_valid = 1'b0;
   logic [7:0]  byte_data = '0;
   logic        byte_ready, ram_we, busy, done;
   logic [15:0] ram_addr;
   logic [11:0] ram_wdata;

   frame_writer #(.ADDR_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .W(W), .H(H), .start(start), .abort(abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;
   logic [15:0] got_addr[$];
   logic [11:0] got_data[$];
   int done_cnt = 0, late_wr = 0;
   logic [7:0] stim[$];

   always @(negedge clk) begin
      if (ram_we) begin
         got_addr.push_back(ram_addr);
         got_data.push_back(ram_wdata);
         if (done_cnt > 0) late_wr++;
      end
      if (done) done_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      got_addr.delete(); got_data.delete();
      done_cnt = 0; late_wr = 0;
   endtask

   task automatic pulse_start(input int w, input int h);
      @(posedge clk); #1;
      start = 1'b1; W = 8'(w); H = 8'(h);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      bit ok = 0;
      byte_valid = 1'b1; byte_data = b;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (byte_ready) ok = 1;
         @(posedge clk); #1;
      end
      byte_valid = 1'b0;
      if (!ok) check("byte_timeout", 0, 1);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
   endtask

   // Model: pixel i goes to address i, built from bytes 2i and upper nibble of 2i+1.
   task automatic verify(input string tag, input int exp_n);
      check({tag, " nwrites"}, got_addr.size(), exp_n);
      for (int i = 0; i < exp_n && i < got_addr.size(); i++) begin
         check($sformatf("%s addr%0d", tag, i), got_addr[i], i);
         check($sformatf("%s data%0d", tag, i), got_data[i],
               {stim[2*i], stim[2*i+1][7:4]});
      end
   endtask

   task automatic run_frame(input string tag, input int w, input int h,
                            input int exp_n, input int gap_max);
      clear_mon();
      pulse_start(w, h);
      foreach (stim[i]) send_byte(stim[i], gap_max);
      wait_done(20);
      verify(tag, exp_n);
      check({tag, " done_cnt"}, done_cnt, 1);
      check({tag, " busy_end"}, busy, 0);
      check({tag, " late_wr"}, late_wr, 0);
   endtask

   task automatic rand_stim(input int n);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
   endtask

   typedef struct { int w; int h; int exp_n; int gap; } vec_t;
   vec_t tbl[7];

   initial begin
      tbl[0] = '{2, 2, 4, 0};
      tbl[1] = '{0, 5, 0, 0};
      tbl[2] = '{5, 0, 0, 1};
      tbl[3] = '{1, 1, 1, 2};
      tbl[4] = '{3, 1, 3, 2};
      tbl[5] = '{16, 16, 256, 1};
      tbl[6] = '{7, 9, 63, 3};

      // reset state
      #3;
      check("rst byte_ready", byte_ready, 0);
      check("rst ram_we", ram_we, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst ram_addr", ram_addr, 0);
      check("rst ram_wdata", ram_wdata, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // fixed stream from the reference example
      stim = '{8'hAB, 8'hC5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
      run_frame("ex", 2, 2, 4, 0);
      check("ex px0", got_data.size() > 0 ? got_data[0] : 12'hFFF, 12'hABC);
      check("ex px3", got_data.size() > 3 ? got_data[3] : 12'hFFF, 12'h9AB);

      // table of frame shapes with random bytes
      for (int t = 0; t < 7; t++) begin
         rand_stim(2 * tbl[t].exp_n);
         run_frame($sformatf("tbl%0d", t), tbl[t].w, tbl[t].h, tbl[t].exp_n, tbl[t].gap);
      end

      // larger frame with random gaps: ascending addresses, single done
      rand_stim(2 * 64 * 40);
      run_frame("big", 64, 40, 2560, 1);

      // empty frame: done exactly two cycles after start
      clear_mon();
      @(posedge clk); #1 start = 1'b1; W = 8'd0; H = 8'd5;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); check("w0 done early", done, 0);
      @(negedge clk); check("w0 done", done, 1);
      @(negedge clk); check("w0 done once", done, 0);
      check("w0 busy", busy, 0);
      check("w0 nwrites", got_addr.size(), 0);

      // abort after first byte of pixel 2
      clear_mon();
      rand_stim(8);
      pulse_start(4, 1);
      for (int i = 0; i < 5; i++) send_byte(stim[i], 0);
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      repeat (6) @(negedge clk);
      verify("abort", 2);
      check("abort done", done_cnt, 0);
      check("abort busy", busy, 0);
      check("abort ready", byte_ready, 0);
      rand_stim(4);
      run_frame("restart", 2, 1, 2, 1);

      // start pulsed mid-frame is ignored
      clear_mon();
      rand_stim(8);
      pulse_start(2, 2);
      for (int i = 0; i < 3; i++) send_byte(stim[i], 0);
      start = 1'b1; W = 8'd9; H = 8'd9;
      @(posedge clk); #1 start = 1'b0;
      for (int i = 3; i < 8; i++) send_byte(stim[i], 0);
      wait_done(20);
      verify("midstart", 4);
      check("midstart done", done_cnt, 1);

      // async reset in the middle of a frame
      clear_mon();
      rand_stim(6);
      pulse_start(3, 1);
      for (int i = 0; i < 3; i++) send_byte(stim[i], 0);
      #2 rst_n = 1'b0;
      #1;
      check("arst byte_ready", byte_ready, 0);
      check("arst ram_we", ram_we, 0);
      check("arst busy", busy, 0);
      check("arst done", done, 0);
      check("arst ram_addr", ram_addr, 0);
      check("arst ram_wdata", ram_wdata, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("post-rst ready", byte_ready, 0);
      check("post-rst busy", busy, 0);
      rand_stim(2);
      run_frame("after_rst", 1, 1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 Parameter ADDR_W, default 16, frame RAM address width.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 W  input  8  image width in pixels; sampled at start.
REQ-005 H  input  8  image height in pixels; sampled at start.
REQ-006 start  input  1  one-cycle request to begin loading a frame.
REQ-007 abort  input  1  cancel the load in progress.
REQ-008 byte_valid  input  1  byte_data holds a valid byte.
REQ-009 byte_data  input  8  incoming image byte stream.
REQ-010 byte_ready  output  1  writer can accept a byte this cycle.
REQ-011 ram_we  output  1  frame RAM write strobe, one cycle per pixel.
REQ-012 ram_addr  output  ADDR_W  frame RAM write address, row-major, pixel 0 at address 0.
REQ-013 ram_wdata  output  12  RGB444 pixel {R,G,B}.
REQ-014 busy  output  1  high from the cycle after accepted start until done or abort.
REQ-015 done  output  1  one-cycle pulse after the final pixel write.

Function
REQ-016 States: IDLE, HI (wait byte 0), LO (wait byte 1), WR (write), FIN; one-hot or binary encoding is free.
REQ-017 The block accepts a byte only on a cycle where byte_valid and byte_ready are both high; byte_ready is high only in HI and LO.
REQ-018 IDLE + start -> latch W, H, total = W*H (16-bit unsigned product), clear pixel counter and address -> HI; if total == 0 -> FIN instead.
REQ-019 HI + accepted byte -> store byte_data as {R,G} -> LO.
REQ-020 LO + accepted byte -> form pixel {stored byte, byte_data[7:4]}; byte_data[3:0] is discarded -> WR.
REQ-021 WR: ram_we=1 for exactly one cycle with ram_addr = pixel counter and ram_wdata = the formed pixel; write latency = 1 cycle after the second byte is accepted.
REQ-022 WR exit: when counter == total-1 -> FIN; otherwise increment counter and address -> HI.
REQ-023 FIN: done=1 for one cycle, busy=0 -> IDLE.
REQ-024 start is ignored outside IDLE; byte_valid in IDLE, WR or FIN is not consumed.
REQ-025 abort in any non-IDLE state -> IDLE on the next edge with no write that cycle, no done pulse, and the partial byte discarded; abort has priority over byte acceptance and the WR write.
REQ-026 The address never exceeds total-1; no wrap beyond the frame.
REQ-027 ram_addr and ram_wdata hold their last values while ram_we=0.
REQ-028 A full 200x150 frame takes exactly 30000 writes covering addresses 0..29999 in ascending order.

Reset
REQ-029 rst_n low -> state IDLE immediately; byte_ready, ram_we, busy and done = 0; ram_addr, ram_wdata, counter and stored byte = 0.
REQ-030 Reset deassertion during a load loses the load; the next start begins from address 0.

Verification
REQ-031 W=2, H=2, start, bytes AB C5 12 34 56 78 9A BC with byte_valid held high -> writes (0,ABC),(1,123),(2,567),(3,9AB), then one done pulse, busy=0.
REQ-032 W=200, H=150, random byte_valid gaps -> 30000 writes, ascending addresses 0..29999, done once, no write after done.
REQ-033 W=0, H=5, start -> no ram_we, done pulse 2 cycles after start.
REQ-034 W=4, H=1, abort asserted after the first byte of pixel 2 -> only addresses 0 and 1 written, no done; a new start rewrites from address 0.
REQ-035 start pulsed again mid-frame -> ignored; counter unaffected.
REQ-036 rst_n pulled low mid-frame -> all outputs 0 asynchronously; after release the block is IDLE with byte_ready=0.
